serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal range 1 to 32).
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to add a and b.
REQ-005 SHALL have port a, input, WIDTH bits, first operand, sampled only when start is accepted.
REQ-006 SHALL have port b, input, WIDTH bits, second operand, sampled only when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit, high while bits are being processed.
REQ-008 SHALL have port done, output, 1 bit, one-cycle pulse when the result is valid.
REQ-009 SHALL have port sum, output, WIDTH bits, registered result, modulo 2^WIDTH.
REQ-010 SHALL have port carry, output, 1 bit, registered carry-out of the MSB.

Function
REQ-011 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-012 In IDLE, start=1 at a rising edge SHALL load a and b into shift registers, clear the carry flop and bit counter, and enter BUSY.
REQ-013 In BUSY, each edge SHALL take bit = a_sh[0] XOR b_sh[0] XOR c, update c = majority(a_sh[0], b_sh[0], c), shift the bit into the MSB of the sum shift register, shift both operand registers right by one, and increment the counter.
REQ-014 BUSY SHALL process exactly WIDTH bits, LSB first; the edge that processes bit WIDTH-1 SHALL enter DONE.
REQ-015 On entry to DONE, sum and carry SHALL load from the sum shift register and the carry flop; at all other times they SHALL hold.
REQ-016 done SHALL be high only in DONE (exactly one cycle); busy SHALL be high only in BUSY; DONE SHALL return to IDLE on the next edge.
REQ-017 Latency: with start sampled at edge T, done SHALL be high between edges T+WIDTH and T+WIDTH+1; throughput SHALL be one operation per WIDTH+2 cycles.
REQ-018 start SHALL be ignored in BUSY and DONE: no operand capture and no effect on the operation in flight.
REQ-019 A start held high across DONE SHALL be accepted on the first IDLE edge.
REQ-020 Changes on a or b after acceptance SHALL NOT affect the result.
REQ-021 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-022 rst_n=0 SHALL immediately force IDLE and zero busy, done, sum, carry, the carry flop, the counter and all shift registers, independent of clk.
REQ-023 A reset asserted mid-BUSY SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL behave as from power-up.

Structure
REQ-024 The IDLE/BUSY/DONE state encodings SHALL be localparams in the shared include file serial_adder_defs.vh.
REQ-025 The per-bit add SHALL be one sub-module, full_adder, built from two half adders plus an OR for the carry, instantiated once.

Verification (WIDTH=8)
REQ-026 a=0x00, b=0x00, start pulse -> done after 8 BUSY cycles, sum=0x00, carry=0.
REQ-027 a=0xFF, b=0x01 -> sum=0x00, carry=1; a=0x80, b=0x80 -> sum=0x00, carry=1.
REQ-028 a=0xA5, b=0x5A -> sum=0xFF, carry=0; busy high for exactly 8 cycles; done high for exactly 1 cycle.
REQ-029 During BUSY, start=1 with a=0x11, b=0x22 -> ignored, and the original 0x0F+0x01 still yields sum=0x10, carry=0.
REQ-030 rst_n low at BUSY cycle 4 -> all outputs 0 at once, no done; a new 0x03+0x04 then yields sum=0x07.
REQ-031 start held high continuously -> consecutive done pulses exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder: state encodings and sizing helpers.
package serial_adder_pkg;

    `include "serial_adder_defs.vh"

    localparam int STATE_W = 2;

    // The counter must be able to hold WIDTH itself, so it never wraps mid-operation.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder built from two half adders with an OR merging their carries.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ha1_sum;
    logic ha1_carry;
    logic ha2_carry;

    assign ha1_sum   = a ^ b;
    assign ha1_carry = a & b;

    assign sum       = ha1_sum ^ cin;
    assign ha2_carry = ha1_sum & cin;

    assign cout      = ha1_carry | ha2_carry;

endmodule

// File: rtl/serial_adder_defs.vh
// FSM state encodings for the serial adder, shared through serial_adder_pkg.
localparam logic [1:0] STATE_IDLE = 2'd0;
localparam logic [1:0] STATE_BUSY = 2'd1;
localparam logic [1:0] STATE_DONE = 2'd2;

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// and presents a registered sum and carry together with a one-cycle done pulse.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    import serial_adder_pkg::*;

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   s_sh_q, s_sh_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic               fa_sum;
    logic               fa_cout;
    logic [WIDTH-1:0]   s_sh_next;

    full_adder u_full_adder (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        s_sh_next            = s_sh_q >> 1;
        s_sh_next[WIDTH-1]   = fa_sum;

        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;

        case (state_q)
            STATE_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    s_sh_d  = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = STATE_BUSY;
                end
            end
            STATE_BUSY: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_sh_d = s_sh_next;
                c_d    = fa_cout;
                cnt_d  = cnt_q + CNT_W'(1);
                // The final bit lands straight in the output registers on the DONE entry edge.
                if (cnt_q == LAST_BIT) begin
                    sum_d   = s_sh_next;
                    carry_d = fa_cout;
                    state_d = STATE_DONE;
                end
            end
            STATE_DONE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STATE_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign busy  = (state_q == STATE_BUSY);
    assign done  = (state_q == STATE_DONE);
    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard-based bench for serial_adder at WIDTH=8: expected sums are queued
// when an operation is launched and compared when done pulses.
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
    } exp_t;

    exp_t sb[$];

    logic timed_out;
    int   busy_cycles;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .carry (carry)
    );

    always #5 clk = ~clk;

    function automatic exp_t model_add(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        logic [WIDTH:0] full;
        exp_t e;
        full    = {1'b0, op_a} + {1'b0, op_b};
        e.sum   = full[WIDTH-1:0];
        e.carry = full[WIDTH];
        return e;
    endfunction

    // Pulses start for one cycle and queues the expected result.
    task automatic start_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        sb.push_back(model_add(op_a, op_b));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles seen along the way.
    task automatic wait_done();
        timed_out   = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic pop_expected(output exp_t e);
        if (sb.size() > 0) e = sb.pop_front();
        else e = 'x;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #3 rst_n = 1'b0;
        #2;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b, expected 0", done); end
        tests_run++;
        if (sum !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_sum: got %h, expected 00", sum); end
        tests_run++;
        if (carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_carry: got %b, expected 0", carry); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_zero();
        exp_t e;
        start_op(8'h00, 8'h00);
        wait_done();
        pop_expected(e);
        tests_run++;
        if (timed_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL zero_timeout: got timed_out=%b, expected 0", timed_out); end
        tests_run++;
        if (busy_cycles != 8) begin tests_failed++; $display("[TB] FAIL zero_busy_cycles: got %0d, expected 8", busy_cycles); end
        tests_run++;
        if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL zero_sum: got %h, expected %h", sum, e.sum); end
        tests_run++;
        if (carry !== e.carry) begin tests_failed++; $display("[TB] FAIL zero_carry: got %b, expected %b", carry, e.carry); end
        @(negedge clk);
    endtask

    task automatic test_carry();
        exp_t e;
        logic [WIDTH-1:0] ops_a [2];
        logic [WIDTH-1:0] ops_b [2];
        ops_a[0] = 8'hFF; ops_b[0] = 8'h01;
        ops_a[1] = 8'h80; ops_b[1] = 8'h80;
        for (int k = 0; k < 2; k++) begin
            start_op(ops_a[k], ops_b[k]);
            wait_done();
            pop_expected(e);
            tests_run++;
            if (timed_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL carry%0d_timeout: got timed_out=%b, expected 0", k, timed_out); end
            tests_run++;
            if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL carry%0d_sum: got %h, expected %h", k, sum, e.sum); end
            tests_run++;
            if (carry !== e.carry) begin tests_failed++; $display("[TB] FAIL carry%0d_carry: got %b, expected %b", k, carry, e.carry); end
            @(negedge clk);
        end
    endtask

    task automatic test_busy_done();
        exp_t e;
        start_op(8'hA5, 8'h5A);
        wait_done();
        pop_expected(e);
        tests_run++;
        if (busy_cycles != 8) begin tests_failed++; $display("[TB] FAIL bd_busy_cycles: got %0d, expected 8", busy_cycles); end
        tests_run++;
        if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL bd_sum: got %h, expected %h", sum, e.sum); end
        tests_run++;
        if (carry !== e.carry) begin tests_failed++; $display("[TB] FAIL bd_carry: got %b, expected %b", carry, e.carry); end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL bd_done_width: got done=%b one cycle later, expected 0", done); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL bd_idle_busy: got busy=%b after done, expected 0", busy); end
        tests_run++;
        if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL bd_sum_hold: got %h, expected %h", sum, e.sum); end
    endtask

    task automatic test_start_ignored();
        exp_t e;
        int   extra_done;
        start_op(8'h0F, 8'h01);
        @(negedge clk);
        a     = 8'h11;
        b     = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_busy: got %b, expected 1", busy); end
        wait_done();
        pop_expected(e);
        tests_run++;
        if (timed_out !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_timeout: got timed_out=%b, expected 0", timed_out); end
        tests_run++;
        if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL ign_sum: got %h, expected %h", sum, e.sum); end
        tests_run++;
        if (carry !== e.carry) begin tests_failed++; $display("[TB] FAIL ign_carry: got %b, expected %b", carry, e.carry); end
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        tests_run++;
        if (extra_done != 0) begin tests_failed++; $display("[TB] FAIL ign_no_extra_op: got %0d active cycles, expected 0", extra_done); end
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        exp_t dropped;
        int   stray_done;
        start_op(8'h12, 8'h34);
        dropped = sb.pop_back();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_busy: got %b, expected 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_done: got %b, expected 0", done); end
        tests_run++;
        if (sum !== 8'h00) begin tests_failed++; $display("[TB] FAIL rst_mid_sum: got %h, expected 00", sum); end
        tests_run++;
        if (carry !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_mid_carry: got %b, expected 0", carry); end
        stray_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) stray_done++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) stray_done++;
        end
        tests_run++;
        if (stray_done != 0) begin tests_failed++; $display("[TB] FAIL rst_mid_no_done: got %0d active cycles, expected 0", stray_done); end
        start_op(8'h03, 8'h04);
        wait_done();
        pop_expected(e);
        tests_run++;
        if (busy_cycles != 8) begin tests_failed++; $display("[TB] FAIL rst_mid_new_busy: got %0d, expected 8", busy_cycles); end
        tests_run++;
        if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL rst_mid_new_sum: got %h, expected %h", sum, e.sum); end
        tests_run++;
        if (carry !== e.carry) begin tests_failed++; $display("[TB] FAIL rst_mid_new_carry: got %b, expected %b", carry, e.carry); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   done_times [3];
        int   n;
        int   cyc;
        logic [WIDTH-1:0] ops_a [3];
        logic [WIDTH-1:0] ops_b [3];
        ops_a[0] = 8'h3C; ops_b[0] = 8'hC3;
        ops_a[1] = 8'h7F; ops_b[1] = 8'h01;
        ops_a[2] = 8'hC8; ops_b[2] = 8'h64;
        n   = 0;
        cyc = 0;
        @(negedge clk);
        a     = ops_a[0];
        b     = ops_b[0];
        start = 1'b1;
        sb.push_back(model_add(ops_a[0], ops_b[0]));
        while (n < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                pop_expected(e);
                tests_run++;
                if (sum !== e.sum) begin tests_failed++; $display("[TB] FAIL b2b%0d_sum: got %h, expected %h", n, sum, e.sum); end
                tests_run++;
                if (carry !== e.carry) begin tests_failed++; $display("[TB] FAIL b2b%0d_carry: got %b, expected %b", n, carry, e.carry); end
                done_times[n] = cyc;
                n++;
                if (n < 3) begin
                    a = ops_a[n];
                    b = ops_b[n];
                    sb.push_back(model_add(ops_a[n], ops_b[n]));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        tests_run++;
        if (n != 3) begin tests_failed++; $display("[TB] FAIL b2b_timeout: got %0d done pulses, expected 3", n); end
        else begin
            tests_run++;
            if (done_times[1] - done_times[0] != 10) begin tests_failed++; $display("[TB] FAIL b2b_gap0: got %0d cycles, expected 10", done_times[1] - done_times[0]); end
            tests_run++;
            if (done_times[2] - done_times[1] != 10) begin tests_failed++; $display("[TB] FAIL b2b_gap1: got %0d cycles, expected 10", done_times[2] - done_times[1]); end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_carry();
        test_busy_done();
        test_start_ignored();
        test_reset_mid_busy();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
